// File: rtl/binary_game_pkg.sv
// Shared definitions for the binary guessing game: state encoding, LFSR shape
// and the level-dependent round length.
package binary_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd3
    } game_state_t;

    localparam int          LFSR_W    = 16;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // max(base - lvl*step, min_t) evaluated in 64 bits so it cannot underflow
    function automatic logic [31:0] round_time(input logic [31:0] lvl,
                                               input logic [31:0] base,
                                               input logic [31:0] min_t,
                                               input logic [31:0] step);
        logic [63:0] dec;
        dec = 64'(lvl) * 64'(step);
        if (dec >= (64'(base) - 64'(min_t)))
            return min_t;
        else
            return base - dec[31:0];
    endfunction

    function automatic int lives_width(input int max_lives);
        return ($clog2(max_lives + 1) > 2) ? $clog2(max_lives + 1) : 2;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it off the all-zero
// lock-up state forever.
module game_lfsr
    import binary_game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_reg <= SEED;
        else
            lfsr_reg <= {1'b0, lfsr_reg[LFSR_W-1:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : '0);
    end

    assign lfsr = lfsr_reg;

endmodule

// File: rtl/binary_game_ctrl.sv
// Round controller for the binary guessing game: FSM, countdown timer, target
// capture, level and lives bookkeeping.
module binary_game_ctrl
    import binary_game_pkg::*;
#(
    parameter int          NUM_W     = 4,
    parameter int          LVL_W     = 8,
    parameter int          TIME_W    = 5,
    parameter int          TICK_DIV  = 50000000,
    parameter int          BASE_TIME = 20,
    parameter int          MIN_TIME  = 5,
    parameter int          TIME_STEP = 1,
    parameter int          MAX_LIVES = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_p,
    input  logic                                guess_p,
    input  logic [NUM_W-1:0]                    guess_val,
    output logic [NUM_W-1:0]                    target,
    output logic [1:0]                          state,
    output logic [LVL_W-1:0]                    level,
    output logic [TIME_W-1:0]                   timeleft,
    output logic [lives_width(MAX_LIVES)-1:0]   lives,
    output logic                                hit_p,
    output logic                                miss_p
);

    localparam int LIVES_W = lives_width(MAX_LIVES);
    localparam int CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    logic [LFSR_W-1:0] lfsr;

    game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    generate
        if (NUM_W < LFSR_W) begin : g_lfsr_spare
            logic lfsr_unused;
            assign lfsr_unused = ^lfsr[LFSR_W-1:NUM_W];
        end
    endgenerate

    game_state_t          state_reg, state_next;
    logic [LVL_W-1:0]     level_reg, level_next, level_inc;
    logic [TIME_W-1:0]    timeleft_reg, timeleft_next;
    logic [LIVES_W-1:0]   lives_reg, lives_next;
    logic [NUM_W-1:0]     target_reg, target_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 hit_reg, hit_next, miss_reg, miss_next;
    logic                 tick, load;
    logic [LVL_W-1:0]     load_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            level_reg    <= '0;
            timeleft_reg <= '0;
            lives_reg    <= LIVES_W'(MAX_LIVES);
            target_reg   <= LFSR_SEED[NUM_W-1:0];
            cnt_reg      <= '0;
            hit_reg      <= 1'b0;
            miss_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            timeleft_reg <= timeleft_next;
            lives_reg    <= lives_next;
            target_reg   <= target_next;
            cnt_reg      <= cnt_next;
            hit_reg      <= hit_next;
            miss_reg     <= miss_next;
        end
    end

    assign tick      = (state_reg == ST_PLAY) && (cnt_reg == TICK_MAX);
    assign level_inc = (level_reg == {LVL_W{1'b1}}) ? level_reg : level_reg + LVL_W'(1);

    always_comb begin
        state_next    = state_reg;
        level_next    = level_reg;
        timeleft_next = timeleft_reg;
        lives_next    = lives_reg;
        target_next   = target_reg;
        cnt_next      = '0;
        hit_next      = 1'b0;
        miss_next     = 1'b0;
        load          = 1'b0;
        load_level    = level_reg;

        if (state_reg == ST_OVER)
            timeleft_next = '0;

        if (start_p) begin
            state_next = ST_PLAY;
            level_next = '0;
            lives_next = LIVES_W'(MAX_LIVES);
            load       = 1'b1;
            load_level = '0;
        end else if (state_reg == ST_PLAY) begin
            // The counter wraps on a tick even when a guess pre-empts it
            cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
            if (guess_p) begin
                if (guess_val == target_reg) begin
                    hit_next   = 1'b1;
                    level_next = level_inc;
                    load       = 1'b1;
                    load_level = level_inc;
                end else begin
                    miss_next  = 1'b1;
                    lives_next = lives_reg - LIVES_W'(1);
                    if (lives_reg == LIVES_W'(1)) begin
                        state_next    = ST_OVER;
                        timeleft_next = '0;
                    end
                end
            end else if (tick) begin
                if (timeleft_reg != '0) begin
                    timeleft_next = timeleft_reg - TIME_W'(1);
                end else begin
                    miss_next  = 1'b1;
                    lives_next = lives_reg - LIVES_W'(1);
                    if (lives_reg == LIVES_W'(1)) begin
                        state_next    = ST_OVER;
                        timeleft_next = '0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
        end

        if (load) begin
            target_next   = lfsr[NUM_W-1:0];
            timeleft_next = TIME_W'(round_time(32'(load_level), BASE_TIME, MIN_TIME, TIME_STEP));
            cnt_next      = '0;
        end
    end

    assign state    = state_reg;
    assign level    = level_reg;
    assign timeleft = timeleft_reg;
    assign lives    = lives_reg;
    assign target   = target_reg;
    assign hit_p    = hit_reg;
    assign miss_p   = miss_reg;

endmodule
